// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared types and the column-merge helper for the dual-port byte-enable RAM
package dp_ram_pkg;

    typedef enum logic [1:0] {
        WRITE_FIRST = 2'd0,
        READ_FIRST  = 2'd1,
        NO_CHANGE   = 2'd2
    } rdw_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Widest word / column count the helper handles; callers pad in and truncate out
    localparam int MAX_W   = 1024;
    localparam int MAX_COL = 128;

    // Columns whose enable bit is set take new data, all others keep the stored data
    function automatic logic [MAX_W-1:0] merge_cols(
        input logic [MAX_W-1:0]   old_w,
        input logic [MAX_W-1:0]   new_w,
        input logic [MAX_COL-1:0] be,
        input int                 col_w
    );
        logic [MAX_W-1:0]   col_mask;
        logic [MAX_W-1:0]   mask;
        logic [MAX_COL-1:0] b;
        col_mask = (MAX_W'(1) << col_w) - MAX_W'(1);
        mask     = '0;
        b        = be;
        for (int c = 0; c < MAX_COL; c++) begin
            if (b[0]) mask = mask | (col_mask << (c * col_w));
            b = b >> 1;
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/dp_ram_clr_seq.sv
// dp_ram_clr_seq: zero-fill sweep sequencer that walks every word address exactly once
module dp_ram_clr_seq
    import dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_e state, state_next;

    // State register and sweep address; the address wraps to 0 after the last word
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_addr <= clr_addr + ADDR_WIDTH'(1);
        end
    end

    // Next state and outputs; clear_i is only sampled in IDLE so a sweep never restarts
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        clr_we     = 1'b0;
        case (state)
            IDLE:    state_next = clear_i ? CLEAR : IDLE;
            CLEAR: begin
                busy_o     = 1'b1;
                clr_we     = 1'b1;
                state_next = (&clr_addr) ? IDLE : CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/dp_ram_be_arb.sv
// dp_ram_be_arb: true dual-port byte-enable RAM with write arbitration, RDW modes and clear sweep
module dp_ram_be_arb
    import dp_ram_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  collision_o,
    input  logic                  en_a_i,
    input  logic                  en_b_i,
    input  logic                  we_a_i,
    input  logic                  we_b_i,
    input  logic [NUM_COL-1:0]    be_a_i,
    input  logic [NUM_COL-1:0]    be_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic                  rvalid_a_o,
    output logic                  rvalid_b_o
);

    localparam int        DEPTH = 2 ** ADDR_WIDTH;
    localparam rdw_mode_e MODE  = rdw_mode_e'(RDW_MODE);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  acc_a, acc_b, wr_a, wr_b, same_addr;
    logic [NUM_COL-1:0]    be_b_eff;
    logic [DATA_WIDTH-1:0] old_a, old_b, resp_a, resp_b;
    logic                  resp_v_a, resp_v_b;
    logic                  rv1_a, rv1_b;
    logic [DATA_WIDTH-1:0] rd1_a, rd1_b;

    dp_ram_clr_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clr_seq (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .busy_o  (busy_o),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // Acceptance, per-column arbitration (A wins overlaps) and each port's read-during-write response
    always_comb begin
        acc_a     = en_a_i && !busy_o;
        acc_b     = en_b_i && !busy_o;
        wr_a      = acc_a && we_a_i;
        wr_b      = acc_b && we_b_i;
        same_addr = addr_a_i == addr_b_i;
        be_b_eff  = (wr_a && same_addr) ? (be_b_i & ~be_a_i) : be_b_i;
        old_a     = mem[addr_a_i];
        old_b     = mem[addr_b_i];
        resp_v_a  = acc_a && !(we_a_i && MODE == NO_CHANGE);
        resp_v_b  = acc_b && !(we_b_i && MODE == NO_CHANGE);
        resp_a    = (we_a_i && MODE == WRITE_FIRST)
                  ? DATA_WIDTH'(merge_cols(MAX_W'(old_a), MAX_W'(wdata_a_i), MAX_COL'(be_a_i), COL_WIDTH))
                  : old_a;
        resp_b    = (we_b_i && MODE == WRITE_FIRST)
                  ? DATA_WIDTH'(merge_cols(MAX_W'(old_b), MAX_W'(wdata_b_i), MAX_COL'(be_b_eff), COL_WIDTH))
                  : old_b;
    end

    // Array update: the sweep owns the array while busy, otherwise both ports write their granted columns
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int c = 0; c < NUM_COL; c++) begin
                if (wr_a && be_a_i[c])
                    mem[addr_a_i][c*COL_WIDTH +: COL_WIDTH] <= wdata_a_i[c*COL_WIDTH +: COL_WIDTH];
                if (wr_b && be_b_eff[c])
                    mem[addr_b_i][c*COL_WIDTH +: COL_WIDTH] <= wdata_b_i[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // First read stage and collision flag; data only moves when a response is produced
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rv1_a       <= 1'b0;
            rv1_b       <= 1'b0;
            rd1_a       <= '0;
            rd1_b       <= '0;
            collision_o <= 1'b0;
        end else begin
            rv1_a       <= resp_v_a;
            rv1_b       <= resp_v_b;
            if (resp_v_a) rd1_a <= resp_a;
            if (resp_v_b) rd1_b <= resp_b;
            collision_o <= wr_a && wr_b && same_addr && |(be_a_i & be_b_i);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rv2_a, rv2_b;
            logic [DATA_WIDTH-1:0] rd2_a, rd2_b;
            // Optional output stage; in-flight responses drain regardless of a sweep starting
            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    rv2_a <= 1'b0;
                    rv2_b <= 1'b0;
                    rd2_a <= '0;
                    rd2_b <= '0;
                end else begin
                    rv2_a <= rv1_a;
                    rv2_b <= rv1_b;
                    if (rv1_a) rd2_a <= rd1_a;
                    if (rv1_b) rd2_b <= rd1_b;
                end
            end
            assign rvalid_a_o = rv2_a;
            assign rvalid_b_o = rv2_b;
            assign rdata_a_o  = rd2_a;
            assign rdata_b_o  = rd2_b;
        end else begin : g_no_out_reg
            assign rvalid_a_o = rv1_a;
            assign rvalid_b_o = rv1_b;
            assign rdata_a_o  = rd1_a;
            assign rdata_b_o  = rd1_b;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_be_arb.sv
// tb_dp_ram_be_arb: self-checking bench driving three RAM configurations from one stimulus stream
module tb_dp_ram_be_arb;

    logic        clk = 1'b0;
    logic        rst_ni, clear_i;
    logic        en_a, we_a, en_b, we_b;
    logic [3:0]  be_a, be_b;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] wd_a, wd_b;
    logic [31:0] rd_a [3];
    logic [31:0] rd_b [3];
    logic        rv_a [3];
    logic        rv_b [3];
    logic        busy [3];
    logic        coll [3];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Instance 0: WRITE_FIRST, no output register
    dp_ram_be_arb #(.RDW_MODE(0), .OUT_REG(0)) u_wf (
        .clk(clk), .rst_ni(rst_ni), .clear_i(clear_i), .busy_o(busy[0]), .collision_o(coll[0]),
        .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b), .be_a_i(be_a), .be_b_i(be_b),
        .addr_a_i(addr_a), .addr_b_i(addr_b), .wdata_a_i(wd_a), .wdata_b_i(wd_b),
        .rdata_a_o(rd_a[0]), .rdata_b_o(rd_b[0]), .rvalid_a_o(rv_a[0]), .rvalid_b_o(rv_b[0])
    );

    // Instance 1: READ_FIRST with output register
    dp_ram_be_arb #(.RDW_MODE(1), .OUT_REG(1)) u_rf (
        .clk(clk), .rst_ni(rst_ni), .clear_i(clear_i), .busy_o(busy[1]), .collision_o(coll[1]),
        .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b), .be_a_i(be_a), .be_b_i(be_b),
        .addr_a_i(addr_a), .addr_b_i(addr_b), .wdata_a_i(wd_a), .wdata_b_i(wd_b),
        .rdata_a_o(rd_a[1]), .rdata_b_o(rd_b[1]), .rvalid_a_o(rv_a[1]), .rvalid_b_o(rv_b[1])
    );

    // Instance 2: NO_CHANGE, no output register
    dp_ram_be_arb #(.RDW_MODE(2), .OUT_REG(0)) u_nc (
        .clk(clk), .rst_ni(rst_ni), .clear_i(clear_i), .busy_o(busy[2]), .collision_o(coll[2]),
        .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b), .be_a_i(be_a), .be_b_i(be_b),
        .addr_a_i(addr_a), .addr_b_i(addr_b), .wdata_a_i(wd_a), .wdata_b_i(wd_b),
        .rdata_a_o(rd_a[2]), .rdata_b_o(rd_b[2]), .rvalid_a_o(rv_a[2]), .rvalid_b_o(rv_b[2])
    );

    // Reference model: word array, sweep cycles remaining, expected outputs per instance
    logic [31:0] mem_m [256];
    int          clr_left;
    logic        ecoll;
    logic        ev_a [3];
    logic        ev_b [3];
    logic        pv_a [3];
    logic        pv_b [3];
    logic [31:0] ed_a [3];
    logic [31:0] ed_b [3];
    logic [31:0] pd_a [3];
    logic [31:0] pd_b [3];

    function automatic logic [31:0] bytemerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = 0;
        ecoll    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ev_a[k] = 1'b0; ev_b[k] = 1'b0; pv_a[k] = 1'b0; pv_b[k] = 1'b0;
            ed_a[k] = '0;   ed_b[k] = '0;   pd_a[k] = '0;   pd_b[k] = '0;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk("rvalid_a", k, 32'(rv_a[k]), 32'(ev_a[k]));
            chk("rdata_a", k, rd_a[k], ed_a[k]);
            chk("rvalid_b", k, 32'(rv_b[k]), 32'(ev_b[k]));
            chk("rdata_b", k, rd_b[k], ed_b[k]);
            chk("busy", k, 32'(busy[k]), 32'(clr_left > 0));
            chk("collision", k, 32'(coll[k]), 32'(ecoll));
        end
    endtask

    // One clock: model the cycle from the driven inputs, let the edge pass, compare at the falling edge
    task automatic cyc();
        logic        busy_now, acc_a, acc_b, wa, wb, same, ncoll;
        logic [3:0]  beb;
        logic        nv_a [3];
        logic        nv_b [3];
        logic [31:0] nd_a [3];
        logic [31:0] nd_b [3];
        busy_now = clr_left > 0;
        acc_a    = en_a && !busy_now;
        acc_b    = en_b && !busy_now;
        wa       = acc_a && we_a;
        wb       = acc_b && we_b;
        same     = addr_a == addr_b;
        beb      = (wa && same) ? (be_b & ~be_a) : be_b;
        ncoll    = wa && wb && same && ((be_a & be_b) != 4'h0);
        for (int k = 0; k < 3; k++) begin
            nv_a[k] = acc_a && !(we_a && k == 2);
            nv_b[k] = acc_b && !(we_b && k == 2);
            nd_a[k] = (we_a && k == 0) ? bytemerge(mem_m[addr_a], wd_a, be_a) : mem_m[addr_a];
            nd_b[k] = (we_b && k == 0) ? bytemerge(mem_m[addr_b], wd_b, beb) : mem_m[addr_b];
        end
        if (busy_now) begin
            mem_m[8'(256 - clr_left)] = '0;
            clr_left--;
        end else begin
            if (clear_i) clr_left = 256;
            if (wb) mem_m[addr_b] = bytemerge(mem_m[addr_b], wd_b, beb);
            if (wa) mem_m[addr_a] = bytemerge(mem_m[addr_a], wd_a, be_a);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                ev_a[k] = pv_a[k]; if (pv_a[k]) ed_a[k] = pd_a[k];
                ev_b[k] = pv_b[k]; if (pv_b[k]) ed_b[k] = pd_b[k];
                pv_a[k] = nv_a[k]; pd_a[k] = nd_a[k];
                pv_b[k] = nv_b[k]; pd_b[k] = nd_b[k];
            end else begin
                ev_a[k] = nv_a[k]; if (nv_a[k]) ed_a[k] = nd_a[k];
                ev_b[k] = nv_b[k]; if (nv_b[k]) ed_b[k] = nd_b[k];
            end
        end
        ecoll = ncoll;
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_ports(
        input logic ea, input logic wa, input logic [3:0] ba, input logic [7:0] aa, input logic [31:0] da,
        input logic eb, input logic wb, input logic [3:0] bb, input logic [7:0] ab, input logic [31:0] db
    );
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; wd_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; wd_b = db;
    endtask

    task automatic randomize_ports();
        en_a   = $urandom_range(0, 3) != 0;
        we_a   = 1'($urandom_range(0, 1));
        be_a   = 4'($urandom);
        addr_a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        wd_a   = $urandom;
        en_b   = $urandom_range(0, 3) != 0;
        we_b   = 1'($urandom_range(0, 1));
        be_b   = 4'($urandom);
        addr_b = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        wd_b   = $urandom;
    endtask

    typedef struct {
        logic        ea, wa; logic [3:0] ba; logic [7:0] aa; logic [31:0] da;
        logic        eb, wb; logic [3:0] bb; logic [7:0] ab; logic [31:0] db;
        logic        x_rv_a; logic [31:0] x_rd_a;
        logic        x_rv_b; logic [31:0] x_rd_b;
        logic        x_coll;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        // Directed vectors with expected WRITE_FIRST (instance 0) outputs after each cycle
        vecs[0] = '{1'b1, 1'b1, 4'hF, 8'h10, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                    1'b1, 32'hAABBCCDD, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'h5, 8'h10, 32'h11223344, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                    1'b1, 32'hAA22CC44, 1'b0, 32'h00000000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0,
                    1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'h3, 8'h20, 32'hAAAAAAAA, 1'b1, 1'b1, 4'h6, 8'h20, 32'hBBBBBBBB,
                    1'b1, 32'h0000AAAA, 1'b1, 32'h00BB0000, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 8'h20, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                    1'b1, 32'h00BBAAAA, 1'b0, 32'h00BB0000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 4'hF, 8'h07, 32'h12345678, 1'b1, 1'b0, 4'h0, 8'h07, 32'h0,
                    1'b1, 32'h12345678, 1'b1, 32'h00000000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'h07, 32'h0,
                    1'b0, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 4'h0, 8'h07, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h0, 8'h07, 32'h0,
                    1'b1, 32'h12345678, 1'b1, 32'h12345678, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 4'h0, 8'h07, 32'h0, 1'b1, 1'b1, 4'hF, 8'h07, 32'hCAFEBABE,
                    1'b1, 32'h12345678, 1'b1, 32'hCAFEBABE, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 4'h0, 8'h07, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0,
                    1'b1, 32'hCAFEBABE, 1'b0, 32'hCAFEBABE, 1'b0};

        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        model_reset();
        set_ports(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        clear_i = 1'b0;
        rst_ni  = 1'b1;
        #2 rst_ni = 1'b0;
        #1 compare_all();
        @(negedge clk);
        rst_ni = 1'b1;

        // Initial sweep gives the array a known all-zero start
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        n = 0;
        while (busy[0] && n < 300) begin cyc(); n++; end
        chk("init_busy_len", 0, n, 256);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            set_ports(vecs[i].ea, vecs[i].wa, vecs[i].ba, vecs[i].aa, vecs[i].da,
                      vecs[i].eb, vecs[i].wb, vecs[i].bb, vecs[i].ab, vecs[i].db);
            cyc();
            chk("vec_rvalid_a", i, 32'(rv_a[0]), 32'(vecs[i].x_rv_a));
            chk("vec_rdata_a", i, rd_a[0], vecs[i].x_rd_a);
            chk("vec_rvalid_b", i, 32'(rv_b[0]), 32'(vecs[i].x_rv_b));
            chk("vec_rdata_b", i, rd_b[0], vecs[i].x_rd_b);
            chk("vec_collision", i, 32'(coll[0]), 32'(vecs[i].x_coll));
        end

        // READ_FIRST with output register: old word returned two cycles after the request
        set_ports(1'b1, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();
        set_ports(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();
        cyc();
        set_ports(1'b1, 1'b1, 4'hF, 8'h05, 32'h11111111, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();
        chk("rf_rvalid_lat1", 1, 32'(rv_a[1]), 32'h0);
        set_ports(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();
        chk("rf_rvalid_lat2", 1, 32'(rv_a[1]), 32'h1);
        chk("rf_rdata", 1, rd_a[1], 32'hDEADBEEF);

        // Reset in the middle of a sweep: partial clear is kept, outputs drop at once
        set_ports(1'b1, 1'b1, 4'hF, 8'd200, 32'hCAFEF00D, 1'b1, 1'b1, 4'hF, 8'd99, 32'h99999999);
        cyc();
        set_ports(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        repeat (100) cyc();
        #1 rst_ni = 1'b0;
        model_reset();
        #1 compare_all();
        #1 rst_ni = 1'b1;
        set_ports(1'b1, 1'b0, 4'h0, 8'd99, 32'h0, 1'b1, 1'b0, 4'h0, 8'd200, 32'h0);
        cyc();
        chk("rst_addr99", 0, rd_a[0], 32'h0);
        chk("rst_addr200", 0, rd_b[0], 32'hCAFEF00D);

        // Randomized traffic against the model, with occasional sweeps
        for (int i = 0; i < 3000; i++) begin
            randomize_ports();
            clear_i = $urandom_range(0, 399) == 0;
            cyc();
        end
        clear_i = 1'b0;
        set_ports(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        n = 0;
        while (clr_left > 0 && n < 300) begin cyc(); n++; end

        // Full sweep with a request accepted alongside clear_i, requests dropped while busy
        set_ports(1'b1, 1'b1, 4'hF, 8'hFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'hF, 8'h80, 32'h80808080);
        cyc();
        set_ports(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        clear_i = 1'b1;
        cyc();
        chk("clear_cycle_rvalid", 0, 32'(rv_a[0]), 32'h1);
        chk("clear_cycle_rdata", 0, rd_a[0], 32'hFFFFFFFF);
        n = 0;
        while (busy[0] && n < 300) begin
            randomize_ports();
            clear_i = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        chk("busy_len", 0, n, 256);
        clear_i = 1'b0;
        set_ports(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'h80, 32'h0);
        cyc();
        chk("cleared_addr00", 0, rd_a[0], 32'h0);
        chk("cleared_addr80", 0, rd_b[0], 32'h0);
        set_ports(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        cyc();
        chk("cleared_addrFF_valid", 0, 32'(rv_a[0]), 32'h1);
        chk("cleared_addrFF", 0, rd_a[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
